// File: rtl/idu0_qdec_pkg.sv
// -----------------------------------------------------------------------------
// idu0_qdec_pkg
// Shared types and constants for decode stage 0.
//   INSTR_LEN, XLEN  : instruction and address widths
//   decode_out_t     : flags produced by the opcode decode table
//   idu0_qentry_t    : raw instruction-queue entry {instr, instr_tag, predicted_taken}
//   idu0_out_t       : decoded packet registered toward IDU1
//   decode_opcode()  : opcode decode table
// -----------------------------------------------------------------------------
package idu0_qdec_pkg;

    localparam int INSTR_LEN = 32;
    localparam int XLEN      = 32;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef struct packed {
        logic legal;
        logic lui;
        logic auipc;
        logic jal;
        logic jalr;
        logic condbr;
        logic load;
        logic store;
        logic imm20;
        logic imm12;
    } decode_out_t;

    typedef struct packed {
        logic [INSTR_LEN-1:0] instr;
        logic [XLEN-1:0]      instr_tag;
        logic                 predicted_taken;
    } idu0_qentry_t;

    typedef struct packed {
        logic [INSTR_LEN-1:0] instr;
        logic [XLEN-1:0]      instr_tag;
        logic                 predicted_taken;
        decode_out_t          dec;
        logic [XLEN-1:0]      imm;
        logic                 imm_valid;
        logic [4:0]           rs1_addr;
        logic [4:0]           rs2_addr;
        logic [4:0]           rd_addr;
        logic [4:0]           shamt;
    } idu0_out_t;

    // Unknown opcodes come back with legal=0 and no class flags set; they are
    // still forwarded so a later stage can raise the trap.
    function automatic decode_out_t decode_opcode(input logic [6:0] opc);
        decode_out_t d;
        d       = '0;
        d.legal = 1'b1;
        case (opc)
            OPC_LUI:    begin d.lui   = 1'b1; d.imm20 = 1'b1; end
            OPC_AUIPC:  begin d.auipc = 1'b1; d.imm20 = 1'b1; end
            OPC_JAL:    begin d.jal   = 1'b1; d.imm20 = 1'b1; end
            OPC_JALR:   begin d.jalr  = 1'b1; d.imm12 = 1'b1; end
            OPC_BRANCH: d.condbr = 1'b1;
            OPC_LOAD:   d.load   = 1'b1;
            OPC_STORE:  d.store  = 1'b1;
            OPC_OPIMM:  d.imm12  = 1'b1;
            OPC_OP:     d.legal  = 1'b1;
            default:    d.legal  = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/idu0_imm_gen.sv
// -----------------------------------------------------------------------------
// idu0_imm_gen
// Combinational immediate generator for the queue head.
//   i_instr     : raw instruction
//   i_dec       : decode-table flags for i_instr
//   o_imm       : sign-extended immediate (J, U, B, S, I/load)
//   o_imm_valid : immediate is an operand (U-type, I-type, load, store)
// -----------------------------------------------------------------------------
module idu0_imm_gen
    import idu0_qdec_pkg::*;
(
    input  logic [INSTR_LEN-1:0] i_instr,
    input  decode_out_t          i_dec,
    output logic [XLEN-1:0]      o_imm,
    output logic                 o_imm_valid
);

    // Opcode bits and the remaining class flags do not select an immediate format.
    logic w_unused;
    assign w_unused = ^{i_instr[6:0], i_dec.legal, i_dec.lui, i_dec.auipc, i_dec.jalr};

    always_comb begin
        o_imm = '0;
        if (i_dec.imm20 && i_dec.jal) begin
            o_imm = {{12{i_instr[31]}}, i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};
        end else if (i_dec.imm20) begin
            o_imm = {i_instr[31:12], 12'b0};
        end else if (i_dec.condbr) begin
            o_imm = {{20{i_instr[31]}}, i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
        end else if (i_dec.store) begin
            o_imm = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
        end else if (i_dec.imm12 || i_dec.load) begin
            o_imm = {{20{i_instr[31]}}, i_instr[31:20]};
        end
    end

    // JAL's offset feeds the branch unit, not the ALU operand path.
    assign o_imm_valid = (i_dec.imm20 & ~i_dec.jal) | i_dec.imm12 | i_dec.load | i_dec.store;

endmodule

// File: rtl/idu0_qdec.sv
// -----------------------------------------------------------------------------
// idu0_qdec
// Decode stage 0: DEPTH-entry instruction queue between the IFU and decode,
// head decode plus immediate generation, and a registered packet toward IDU1.
// Optional build macro: IDU0_QDEC_PERF_CNT_EN adds two saturating perf counters.
//   clk, rst                  : clock, synchronous active-high reset
//   instr, instr_valid,
//   instr_tag,
//   predicted_taken_from_ifu  : IFU offer
//   ifu_ready                 : queue can accept this cycle (count != DEPTH)
//   pipe_stall                : IDU1 cannot accept the output register
//   pipe_flush                : discard everything in flight
//   idu0_out, idu0_out_valid  : decoded packet and its valid
//   occupancy                 : queue entry count (0..DEPTH)
//   perf_stall_cycles         : (macro) cycles with idu0_out_valid & pipe_stall
//   perf_ifu_bp_cycles        : (macro) cycles with instr_valid & ~ifu_ready
// -----------------------------------------------------------------------------
module idu0_qdec
    import idu0_qdec_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [INSTR_LEN-1:0] instr,
    input  logic                 instr_valid,
    input  logic [XLEN-1:0]      instr_tag,
    input  logic                 predicted_taken_from_ifu,
    output logic                 ifu_ready,
    input  logic                 pipe_stall,
    input  logic                 pipe_flush,
    output idu0_out_t            idu0_out,
    output logic                 idu0_out_valid,
    output logic [PTR_W:0]       occupancy
`ifdef IDU0_QDEC_PERF_CNT_EN
    ,
    output logic [31:0]          perf_stall_cycles,
    output logic [31:0]          perf_ifu_bp_cycles
`endif
);

    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    idu0_qentry_t     r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W:0]   r_count;
    idu0_out_t        r_out_p1;
    logic             r_vld_p1;

    idu0_qentry_t     w_head_p0;
    decode_out_t      w_dec_p0;
    logic [XLEN-1:0]  w_imm_p0;
    logic             w_imm_valid_p0;
    idu0_out_t        w_out_p0;
    logic             w_push;
    logic             w_pop;

    // Ready depends only on the registered count, so a same-cycle pop never
    // frees a slot for the IFU; this keeps the pop path out of ifu_ready.
    assign ifu_ready = (r_count != CNT_FULL);
    assign w_push    = instr_valid & ifu_ready & ~pipe_flush;
    assign w_pop     = (r_count != '0) & (~r_vld_p1 | ~pipe_stall) & ~pipe_flush;

    // Queue storage holds raw bits; it needs no reset because the pointers gate reads.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= '{instr:           instr,
                                 instr_tag:       instr_tag,
                                 predicted_taken: predicted_taken_from_ifu};
        end
    end

    // ---- Stage p0: decode of the queue head --------------------------------
    assign w_head_p0 = r_mem[r_rd_ptr];
    assign w_dec_p0  = decode_opcode(w_head_p0.instr[6:0]);

    idu0_imm_gen u_imm_gen (
        .i_instr     (w_head_p0.instr),
        .i_dec       (w_dec_p0),
        .o_imm       (w_imm_p0),
        .o_imm_valid (w_imm_valid_p0)
    );

    always_comb begin
        w_out_p0                 = '0;
        w_out_p0.instr           = w_head_p0.instr;
        w_out_p0.instr_tag       = w_head_p0.instr_tag;
        w_out_p0.predicted_taken = w_head_p0.predicted_taken;
        w_out_p0.dec             = w_dec_p0;
        w_out_p0.imm             = w_imm_p0;
        w_out_p0.imm_valid       = w_imm_valid_p0;
        w_out_p0.rs1_addr        = w_head_p0.instr[19:15];
        w_out_p0.rs2_addr        = w_head_p0.instr[24:20];
        w_out_p0.rd_addr         = w_head_p0.instr[11:7];
        w_out_p0.shamt           = w_head_p0.instr[24:20];
    end

    // ---- Stage p1: queue control and output register -----------------------
    always_ff @(posedge clk) begin
        if (rst || pipe_flush) begin
            r_count  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_vld_p1 <= 1'b0;
            r_out_p1 <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
            if (w_pop) begin
                r_out_p1 <= w_out_p0;
                r_vld_p1 <= 1'b1;
            end else if (!pipe_stall) begin
                r_vld_p1 <= 1'b0;
            end
        end
    end

    assign idu0_out       = r_out_p1;
    assign idu0_out_valid = r_vld_p1;
    assign occupancy      = r_count;

`ifdef IDU0_QDEC_PERF_CNT_EN
    logic [31:0] r_perf_stall;
    logic [31:0] r_perf_bp;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Only reset clears the counters; flush leaves them running.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_stall <= '0;
            r_perf_bp    <= '0;
        end else begin
            if (r_vld_p1 && pipe_stall)    r_perf_stall <= sat_inc(r_perf_stall);
            if (instr_valid && !ifu_ready) r_perf_bp    <= sat_inc(r_perf_bp);
        end
    end

    assign perf_stall_cycles  = r_perf_stall;
    assign perf_ifu_bp_cycles = r_perf_bp;
`endif

endmodule

// File: tb/tb_idu0_qdec.sv
module tb_idu0_qdec;
    import idu0_qdec_pkg::*;

    localparam int DEPTH = 4;
    localparam int PTR_W = $clog2(DEPTH);

    logic                 clk = 1'b0;
    logic                 rst;
    logic [INSTR_LEN-1:0] instr;
    logic                 instr_valid;
    logic [XLEN-1:0]      instr_tag;
    logic                 predicted_taken_from_ifu;
    logic                 ifu_ready;
    logic                 pipe_stall;
    logic                 pipe_flush;
    idu0_out_t            idu0_out;
    logic                 idu0_out_valid;
    logic [PTR_W:0]       occupancy;
`ifdef IDU0_QDEC_PERF_CNT_EN
    logic [31:0]          perf_stall_cycles;
    logic [31:0]          perf_ifu_bp_cycles;
`endif

    idu0_qdec #(.DEPTH(DEPTH)) dut (
        .clk                      (clk),
        .rst                      (rst),
        .instr                    (instr),
        .instr_valid              (instr_valid),
        .instr_tag                (instr_tag),
        .predicted_taken_from_ifu (predicted_taken_from_ifu),
        .ifu_ready                (ifu_ready),
        .pipe_stall               (pipe_stall),
        .pipe_flush               (pipe_flush),
        .idu0_out                 (idu0_out),
        .idu0_out_valid           (idu0_out_valid),
        .occupancy                (occupancy)
`ifdef IDU0_QDEC_PERF_CNT_EN
        ,
        .perf_stall_cycles        (perf_stall_cycles),
        .perf_ifu_bp_cycles       (perf_ifu_bp_cycles)
`endif
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Hand-computed decode results for every instruction the bench issues.
    typedef struct packed {
        logic [31:0] imm;
        logic        iv;
        logic        legal;
        logic        jal;
        logic        condbr;
    } ref_t;

    function automatic ref_t ref_of(input logic [31:0] ins);
        ref_t r;
        r = '{imm: 32'h0, iv: 1'b0, legal: 1'b1, jal: 1'b0, condbr: 1'b0};
        case (ins)
            32'h00510093: begin r.imm = 32'h0000_0005; r.iv = 1'b1; end  // addi x1,x2,5
            32'h001000EF: begin r.imm = 32'h0000_0800; r.jal = 1'b1; end // jal x1,+2048
            32'hFE000EE3: begin r.imm = 32'hFFFF_FFFC; r.condbr = 1'b1; end // beq x0,x0,-4
            32'h123452B7: begin r.imm = 32'h1234_5000; r.iv = 1'b1; end  // lui x5,0x12345
            32'h00612423: begin r.imm = 32'h0000_0008; r.iv = 1'b1; end  // sw x6,8(x2)
            32'hFFC5A503: begin r.imm = 32'hFFFF_FFFC; r.iv = 1'b1; end  // lw x10,-4(x11)
            32'h002081B3: r.legal = 1'b1;                                 // add x3,x1,x2
            default:      r.legal = 1'b0;                                 // 0, 0xFFFFFFFF
        endcase
        return r;
    endfunction

    logic [31:0] prog [8];
    initial begin
        prog[0] = 32'h00510093; prog[1] = 32'h001000EF;
        prog[2] = 32'hFE000EE3; prog[3] = 32'h123452B7;
        prog[4] = 32'h00612423; prog[5] = 32'hFFC5A503;
        prog[6] = 32'hFFFFFFFF; prog[7] = 32'h002081B3;
    end

    // Behavioural model: a plain FIFO queue plus one output slot.
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] tag;
        logic        pt;
    } ment_t;

    ment_t       mq[$];
    ment_t       m_out = '0;
    logic        m_valid = 1'b0;
    logic [31:0] m_perf_stall = '0;
    logic [31:0] m_perf_bp = '0;
    logic [31:0] consumed[$];
    bit          started = 1'b0;
    bit          seen_3ff = 1'b0;

    always @(posedge clk) begin : model
        bit    full_pre;
        bit    can_pop;
        ment_t e;
        started  = 1'b1;
        full_pre = (mq.size() == DEPTH);
        if (rst) begin
            m_perf_stall = '0;
            m_perf_bp    = '0;
        end else begin
            if (m_valid && pipe_stall && m_perf_stall != 32'hFFFF_FFFF) m_perf_stall++;
            if (instr_valid && full_pre && m_perf_bp != 32'hFFFF_FFFF) m_perf_bp++;
        end
        if (rst || pipe_flush) begin
            mq.delete();
            m_valid = 1'b0;
            m_out   = '0;
        end else begin
            if (m_valid && !pipe_stall) consumed.push_back(m_out.tag);
            can_pop = (mq.size() != 0) && (!m_valid || !pipe_stall);
            if (can_pop) begin
                m_out   = mq.pop_front();
                m_valid = 1'b1;
            end else if (!pipe_stall) begin
                m_valid = 1'b0;
            end
            if (instr_valid && !full_pre) begin
                e = '{instr: instr, tag: instr_tag, pt: predicted_taken_from_ifu};
                mq.push_back(e);
            end
        end
    end

    ref_t r_exp;
    always @(negedge clk) begin
        if (started) begin
            r_exp = ref_of(m_out.instr);
            chk("occupancy", 64'(occupancy), 64'(mq.size()));
            chk("ifu_ready", 64'(ifu_ready), 64'(mq.size() != DEPTH));
            chk("out_valid", 64'(idu0_out_valid), 64'(m_valid));
            chk("out_instr", 64'(idu0_out.instr), 64'(m_out.instr));
            chk("out_tag", 64'(idu0_out.instr_tag), 64'(m_out.tag));
            chk("out_pt", 64'(idu0_out.predicted_taken), 64'(m_out.pt));
            chk("out_imm", 64'(idu0_out.imm), 64'(r_exp.imm));
            chk("out_imm_valid", 64'(idu0_out.imm_valid), 64'(r_exp.iv));
            chk("out_legal", 64'(idu0_out.dec.legal), 64'(r_exp.legal));
            chk("out_jal", 64'(idu0_out.dec.jal), 64'(r_exp.jal));
            chk("out_condbr", 64'(idu0_out.dec.condbr), 64'(r_exp.condbr));
            chk("out_rs1", 64'(idu0_out.rs1_addr), 64'(m_out.instr[19:15]));
            chk("out_rs2", 64'(idu0_out.rs2_addr), 64'(m_out.instr[24:20]));
            chk("out_rd", 64'(idu0_out.rd_addr), 64'(m_out.instr[11:7]));
`ifdef IDU0_QDEC_PERF_CNT_EN
            chk("perf_stall", 64'(perf_stall_cycles), 64'(m_perf_stall));
            chk("perf_bp", 64'(perf_ifu_bp_cycles), 64'(m_perf_bp));
`endif
            if (idu0_out_valid === 1'b1 && idu0_out.instr_tag == 32'h3FF) seen_3ff = 1'b1;
        end
    end

    task automatic push(input logic [31:0] ins, input logic [31:0] tag, input logic pt);
        instr_valid = 1'b1;
        instr = ins;
        instr_tag = tag;
        predicted_taken_from_ifu = pt;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        instr_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin : stim
        int k;
        int cyc;
        rst = 1'b1; instr_valid = 1'b0; instr = '0; instr_tag = '0;
        predicted_taken_from_ifu = 1'b0; pipe_stall = 1'b0; pipe_flush = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_occupancy", 64'(occupancy), 64'd0);
        chk("rst_ifu_ready", 64'(ifu_ready), 64'd1);
        chk("rst_valid", 64'(idu0_out_valid), 64'd0);
        chk("rst_payload", 64'(idu0_out.instr_tag | idu0_out.instr), 64'd0);

        // ADDI: two edges from offer to a live output
        push(32'h00510093, 32'h0000_0100, 1'b0);
        idle(1);
        chk("addi_valid", 64'(idu0_out_valid), 64'd1);
        chk("addi_imm", 64'(idu0_out.imm), 64'h5);
        chk("addi_rs1", 64'(idu0_out.rs1_addr), 64'd2);
        chk("addi_rd", 64'(idu0_out.rd_addr), 64'd1);
        chk("addi_imm_valid", 64'(idu0_out.imm_valid), 64'd1);
        chk("addi_tag", 64'(idu0_out.instr_tag), 64'h100);
        chk("addi_occupancy", 64'(occupancy), 64'd0);

        // JAL then BEQ back to back
        push(32'h001000EF, 32'h0000_0110, 1'b1);
        push(32'hFE000EE3, 32'h0000_0114, 1'b0);
        chk("jal_imm", 64'(idu0_out.imm), 64'h800);
        chk("jal_imm_valid", 64'(idu0_out.imm_valid), 64'd0);
        chk("jal_flag", 64'(idu0_out.dec.jal), 64'd1);
        chk("jal_pt", 64'(idu0_out.predicted_taken), 64'd1);
        idle(1);
        chk("beq_imm", 64'(idu0_out.imm), 64'hFFFF_FFFC);
        chk("beq_condbr", 64'(idu0_out.dec.condbr), 64'd1);
        for (int i = 3; i < 8; i++) push(prog[i], 32'h120 + 32'(i), 1'(i));
        idle(3);

        // Full queue under stall: 5 accepted, the 6th refused
        pipe_stall = 1'b1;
        for (int i = 0; i < 6; i++) push(prog[i], 32'h200 + 32'(i), 1'b0);
        instr_valid = 1'b0;
        chk("full_ready", 64'(ifu_ready), 64'd0);
        chk("full_occupancy", 64'(occupancy), 64'd4);
        chk("full_head_tag", 64'(idu0_out.instr_tag), 64'h200);
        pipe_stall = 1'b0;
        for (int i = 1; i < 5; i++) begin
            @(negedge clk);
            chk("drain_valid", 64'(idu0_out_valid), 64'd1);
            chk("drain_tag", 64'(idu0_out.instr_tag), 64'(32'h200 + 32'(i)));
        end
        @(negedge clk);
        chk("drain_bubble", 64'(idu0_out_valid), 64'd0);

        // Flush beats stall and the same-cycle push
        pipe_stall = 1'b1;
        for (int i = 0; i < 4; i++) push(prog[i], 32'h300 + 32'(i), 1'b0);
        chk("preflush_occupancy", 64'(occupancy), 64'd3);
        chk("preflush_valid", 64'(idu0_out_valid), 64'd1);
        pipe_flush = 1'b1;
        push(32'h00510093, 32'h3FF, 1'b0);
        pipe_flush = 1'b0;
        instr_valid = 1'b0;
        chk("flush_valid", 64'(idu0_out_valid), 64'd0);
        chk("flush_occupancy", 64'(occupancy), 64'd0);
        chk("flush_payload", 64'(idu0_out.instr_tag), 64'd0);
        pipe_stall = 1'b0;
        idle(4);
        chk("flush_drop", 64'(seen_3ff), 64'd0);

        // Wrap: 20 accepted pushes with alternating stall
        consumed.delete();
        k = 0;
        cyc = 0;
        while (k < 20 && cyc < 200) begin
            pipe_stall = cyc[0];
            instr_valid = 1'b1;
            instr = prog[k % 8];
            instr_tag = 32'h400 + 32'(k);
            predicted_taken_from_ifu = k[0];
            if (ifu_ready) k++;
            @(negedge clk);
            cyc++;
        end
        pipe_stall = 1'b0;
        idle(8);
        chk("wrap_accepted", 64'(k), 64'd20);
        chk("wrap_count", 64'(consumed.size()), 64'd20);
        for (int i = 0; i < 20 && i < consumed.size(); i++)
            chk("wrap_order", 64'(consumed[i]), 64'(32'h400 + 32'(i)));

        // Reset mid-operation
        pipe_stall = 1'b1;
        for (int i = 0; i < 3; i++) push(prog[i], 32'h500 + 32'(i), 1'b0);
        instr_valid = 1'b0;
        chk("prerst_occupancy", 64'(occupancy), 64'd2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        pipe_stall = 1'b0;
        chk("midrst_occupancy", 64'(occupancy), 64'd0);
        chk("midrst_ready", 64'(ifu_ready), 64'd1);
        chk("midrst_valid", 64'(idu0_out_valid), 64'd0);
        chk("midrst_payload", 64'(idu0_out.instr_tag | idu0_out.instr), 64'd0);

`ifdef IDU0_QDEC_PERF_CNT_EN
        pipe_stall = 1'b1;
        for (int i = 0; i < 5; i++) push(prog[i], 32'h600 + 32'(i), 1'b0);
        for (int i = 0; i < 10; i++) push(prog[0], 32'h6FF, 1'b0);
        instr_valid = 1'b0;
        chk("perf_bp_10", 64'(perf_ifu_bp_cycles), 64'd10);
        chk("perf_stall_13", 64'(perf_stall_cycles), 64'd13);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        pipe_stall = 1'b0;
        chk("perf_rst_bp", 64'(perf_ifu_bp_cycles), 64'd0);
        chk("perf_rst_stall", 64'(perf_stall_cycles), 64'd0);
`endif
        idle(3);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
